// File: rtl/fanin_pkg.sv
// Shared types and helpers for the fan-in merge arbiter: configuration masks,
// default sizing and the round-robin pick function.
package fanin_pkg;

    localparam int NUM_IN     = 9;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 2;
    localparam int IDX_W      = $clog2(NUM_IN);

    // rr_pick works on a fixed-width mask so any NUM_IN up to MAX_IN can share it
    localparam int MAX_IN = 32;
    localparam int PICK_W = $clog2(MAX_IN);

    typedef struct packed {
        logic [MAX_IN-1:0] en;
        logic [MAX_IN-1:0] sel;
    } fanin_cfg_t;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } rr_pick_t;

    // First set bit of mask[0 +: n] scanning ptr, ptr+1, ... wrapping at n (not at a power of 2)
    function automatic rr_pick_t rr_pick(input logic [MAX_IN-1:0] mask,
                                         input logic [PICK_W-1:0] ptr,
                                         input int                n);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (i < n && !r.found) begin
                idx = int'(ptr) + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (mask[idx]) begin
                    r.found = 1'b1;
                    r.idx   = PICK_W'(idx);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fanin_merge_arbiter_fifo.sv
// Small register-based FIFO with full/empty flags; push and pop may happen in the
// same cycle, and a pop frees the slot a simultaneous push needs when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else if (do_push && wr_ptr_q == PTR_W'(gi)) begin
                mem_q[gi] <= din;
            end
        end
    end

endmodule

// File: rtl/fanin_merge_arbiter.sv
// Merges NUM_IN valid/ready streams onto one output through a round-robin arbiter
// and a small FIFO; each output word carries the index of the input that sent it.
module fanin_merge_arbiter
    import fanin_pkg::*;
#(
    parameter int NUM_IN     = fanin_pkg::NUM_IN,
    parameter int DATA_W     = fanin_pkg::DATA_W,
    parameter int FIFO_DEPTH = fanin_pkg::FIFO_DEPTH
) (
    input  logic                       CLK,
    input  logic                       ASYNCRESET,
    input  logic [NUM_IN-1:0]          en,
    input  logic [NUM_IN-1:0]          sel,
    input  logic [NUM_IN-1:0]          in_valid,
    input  logic [NUM_IN*DATA_W-1:0]   in_data,
    output logic [NUM_IN-1:0]          in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_IN)-1:0]  out_src,
    input  logic                       out_ready
);

    localparam int SRC_W = $clog2(NUM_IN);

    fanin_cfg_t              cfg;
    logic [MAX_IN-1:0]       elig;
    rr_pick_t                pick;
    logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]        grant_idx;
    logic                    grant;
    logic                    space;
    logic                    fifo_full, fifo_empty;
    logic [DATA_W+SRC_W-1:0] push_word, head_word;

    always_comb begin
        cfg     = '0;
        cfg.en  = MAX_IN'(en);
        cfg.sel = MAX_IN'(sel);
        elig    = cfg.en & cfg.sel & MAX_IN'(in_valid);
        pick    = rr_pick(elig, PICK_W'(rr_ptr_q), NUM_IN);

        // A pop in this cycle frees a slot, so a full FIFO can still accept
        space     = ~fifo_full | (out_ready & ~fifo_empty);
        grant     = pick.found & space & ~ASYNCRESET;
        grant_idx = SRC_W'(pick.idx);

        in_ready = '0;
        if (grant) begin
            in_ready[grant_idx] = 1'b1;
        end

        push_word = {in_data[grant_idx*DATA_W +: DATA_W], grant_idx};

        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (grant_idx == SRC_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + SRC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (ASYNCRESET),
        .push  (grant),
        .din   (push_word),
        .pop   (out_ready),
        .dout  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head_word[SRC_W +: DATA_W];
    assign out_src   = head_word[SRC_W-1:0];

endmodule

// File: tb/tb_fanin_merge_arbiter.sv
// Bench for fanin_merge_arbiter: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed grant and source sequences.
module tb_fanin_merge_arbiter;

    localparam int N  = 9;
    localparam int DW = 16;
    localparam int FD = 2;
    localparam int SW = 4;

    logic            CLK = 1'b0;
    logic            ASYNCRESET = 1'b1;
    logic [N-1:0]    en = '0;
    logic [N-1:0]    sel = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    fanin_merge_arbiter dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .en         (en),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as queues, round-robin pointer as an integer
    int           mq_data[$];
    int           mq_src[$];
    int           m_rr = 0;
    int           m_g = -1;
    int           m_gdata = 0;
    bit           m_pop = 1'b0;
    logic [N-1:0] m_elig;
    logic [N-1:0] m_rdy;
    int           m_sz;
    bit           m_space;

    always begin
        @(negedge CLK);
        if (ASYNCRESET) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_src", out_src, 0);
            mq_data.delete();
            mq_src.delete();
            m_rr  = 0;
            m_g   = -1;
            m_pop = 1'b0;
        end else begin
            m_elig  = en & sel & in_valid;
            m_sz    = mq_src.size();
            m_space = (m_sz < FD) || (out_ready && m_sz > 0);
            m_g     = -1;
            if (m_space) begin
                for (int k = 0; k < N; k++) begin
                    if (m_g < 0 && m_elig[(m_rr + k) % N]) m_g = (m_rr + k) % N;
                end
            end
            m_rdy = '0;
            if (m_g >= 0) begin
                m_rdy[m_g] = 1'b1;
                m_gdata    = int'(in_data[m_g*DW +: DW]);
            end
            chk("model_in_ready", in_ready, m_rdy);
            chk("model_out_valid", out_valid, (m_sz > 0) ? 1 : 0);
            if (m_sz > 0) begin
                chk("model_out_data", out_data, mq_data[0]);
                chk("model_out_src", out_src, mq_src[0]);
            end
            m_pop = out_ready && (m_sz > 0);
        end
        @(posedge CLK);
        if (m_pop) begin
            void'(mq_data.pop_front());
            void'(mq_src.pop_front());
        end
        if (m_g >= 0) begin
            mq_data.push_back(m_gdata);
            mq_src.push_back(m_g);
            m_rr = (m_g + 1) % N;
        end
        m_g   = -1;
        m_pop = 1'b0;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_data(input int salt);
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(salt + i);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1 ASYNCRESET = 1'b0;
        @(negedge CLK);
        chk("post_reset_out_valid", out_valid, 0);

        // Fairness: every input eligible, one output per cycle in index order
        tick();
        en = '1; sel = '1; in_valid = '1; out_ready = 1'b1;
        set_data(0);
        for (int k = 0; k < 19; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                chk("fair_latency", out_valid, 0);
            end else begin
                chk("fair_valid", out_valid, 1);
                chk("fair_src", out_src, (k - 1) % N);
                chk("fair_data", out_data, (k - 1) % N);
            end
        end
        tick();
        in_valid = '0;
        repeat (3) tick();

        // Masking: only inputs 0 and 2 selected; pointer is at 1
        sel = 9'h005; in_valid = '1;
        set_data(16'h300);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            chk("mask_in_ready", in_ready, (k % 2 == 1) ? 9'h001 : 9'h004);
        end
        tick();
        in_valid = '0;
        repeat (3) tick();

        // Backpressure: fill with src 3 then 4, then one pop/push cycle
        sel = '1; out_ready = 1'b0; in_valid = 9'h018;
        set_data(16'h400);
        @(negedge CLK); chk("bp_grant3", in_ready, 9'h008);
        @(negedge CLK); chk("bp_grant4", in_ready, 9'h010);
        @(negedge CLK); chk("bp_full_rdy", in_ready, 0); chk("bp_head", out_src, 3);
        tick();
        out_ready = 1'b1;
        @(negedge CLK); chk("bp_popush_rdy", in_ready, 9'h008); chk("bp_pop_src", out_src, 3);
        tick();
        out_ready = 1'b0;
        @(negedge CLK); chk("bp_still_full", in_ready, 0); chk("bp_head2", out_src, 4);
        tick();
        in_valid = '0; out_ready = 1'b1;
        repeat (3) tick();

        // Sparse wrap: pointer reaches 8 via a grant to 7
        set_data(16'h500);
        in_valid = 9'h080;
        @(negedge CLK); chk("wrap_g7", in_ready, 9'h080);
        tick(); in_valid = 9'h100;
        @(negedge CLK); chk("wrap_g8", in_ready, 9'h100);
        tick(); in_valid = 9'h002;
        @(negedge CLK); chk("wrap_g1", in_ready, 9'h002);
        tick(); in_valid = 9'h006;
        @(negedge CLK); chk("wrap_ptr2", in_ready, 9'h004);
        tick();
        in_valid = '0;
        repeat (3) tick();

        // Config flip: queued entry from 2 drains after sel[2] is cleared
        out_ready = 1'b0; in_valid = 9'h004;
        set_data(16'h600);
        @(negedge CLK); chk("flip_g2", in_ready, 9'h004);
        tick();
        sel = 9'h1FB; out_ready = 1'b1;
        @(negedge CLK); chk("flip_no_grant", in_ready, 0); chk("flip_src", out_src, 2);
        chk("flip_valid", out_valid, 1);
        tick();
        @(negedge CLK); chk("flip_drained", out_valid, 0); chk("flip_no_grant2", in_ready, 0);
        tick();
        in_valid = '0; sel = '1;

        // Reset mid-traffic with two entries queued
        out_ready = 1'b0; in_valid = 9'h018;
        set_data(16'h700);
        @(negedge CLK); chk("rst_g3", in_ready, 9'h008);
        @(negedge CLK); chk("rst_g4", in_ready, 9'h010);
        @(posedge CLK);
        #1 chk("rst_pre_valid", out_valid, 1);
        #1 ASYNCRESET = 1'b1;
        #1 chk("rst_now_valid", out_valid, 0); chk("rst_now_ready", in_ready, 0);
        @(posedge CLK);
        #1 ASYNCRESET = 1'b0; in_valid = '1;
        @(negedge CLK); chk("rst_first_grant", in_ready, 9'h001);
        tick();
        in_valid = '0; out_ready = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
